// File: rtl/tx_pattern_engine.sv
// Parallel word source for the TX serializer: pass-through, multi-polynomial PRBS,
// static and toggle patterns, one-shot error injection and optional lane interleave.
module tx_pattern_engine #(
    parameter int          WIDTH   = 16,
    parameter int          NLANE   = 4,
    parameter bit          REORDER = 1,
    parameter logic [30:0] SEED    = 31'h7FFFFFFF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cke,
    input  logic [1:0]       mode,
    input  logic [1:0]       prbs_sel,
    input  logic [WIDTH-1:0] din,
    input  logic [WIDTH-1:0] pat,
    input  logic             inj_error,
    output logic [WIDTH-1:0] dout,
    output logic [7:0]       inj_cnt
);
    localparam int M  = WIDTH / NLANE;
    localparam int LM = $clog2(M);

    logic [WIDTH-1:0] dout_q, dout_d;
    logic [7:0]       inj_cnt_q, inj_cnt_d;
    logic [30:0]      state_q, state_d;
    logic [1:0]       mode_q, mode_d;
    logic [1:0]       prbs_sel_q, prbs_sel_d;
    logic             inj_q;
    logic             pending_q, pending_d;
    logic             phase_q, phase_d;

    logic             pend_w;
    logic             reseed;
    logic             ph;
    logic             nb;
    logic [30:0]      mask;
    logic [30:0]      s;
    logic [WIDTH-1:0] raw;

    function automatic int rev(input int a);
        int r;
        r = 0;
        for (int i = 0; i < LM; i++) begin
            if (a[i]) r = r | (1 << (LM - 1 - i));
        end
        return r;
    endfunction

    always_comb begin
        case (prbs_sel)
            2'd0:    mask = 31'h0000007F;
            2'd1:    mask = 31'h00007FFF;
            default: mask = 31'h7FFFFFFF;
        endcase
    end

    always_comb begin
        dout_d     = dout_q;
        inj_cnt_d  = inj_cnt_q;
        state_d    = state_q;
        mode_d     = mode_q;
        prbs_sel_d = prbs_sel_q;
        phase_d    = phase_q;
        raw        = '0;
        ph         = 1'b0;
        nb         = 1'b0;
        s          = state_q;
        reseed     = 1'b0;
        // A request seen in this very cycle still lands on this cycle's word.
        pend_w     = pending_q | (inj_error & ~inj_q);
        pending_d  = pend_w;

        if (cke) begin
            mode_d     = mode;
            prbs_sel_d = prbs_sel;
            case (mode)
                2'd0: raw = din;
                2'd2: raw = pat;
                2'd3: begin
                    ph      = (mode_q == 2'd3) ? phase_q : 1'b0;
                    raw     = ph ? ~pat : pat;
                    phase_d = ~ph;
                end
                default: begin
                    reseed = (mode_q != 2'd1) || (prbs_sel != prbs_sel_q) ||
                             ((state_q & mask) == '0);
                    s = reseed ? SEED : state_q;
                    for (int k = 0; k < WIDTH; k++) begin
                        case (prbs_sel)
                            2'd0:    nb = s[6]  ^ s[5];
                            2'd1:    nb = s[14] ^ s[13];
                            default: nb = s[30] ^ s[27];
                        endcase
                        s = {s[29:0], nb};
                        raw[WIDTH-1-k] = nb;
                    end
                    state_d = s & mask;
                end
            endcase

            if (pend_w) begin
                raw[WIDTH-1] = ~raw[WIDTH-1];
                pending_d    = 1'b0;
                if (inj_cnt_q != 8'hFF) inj_cnt_d = inj_cnt_q + 8'd1;
            end

            if (REORDER) begin
                for (int a = 0; a < M; a++) begin
                    for (int b = 0; b < NLANE; b++) begin
                        dout_d[M*b + rev(a)] = raw[WIDTH-1-(NLANE*a+b)];
                    end
                end
            end else begin
                dout_d = raw;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dout_q     <= '0;
            inj_cnt_q  <= '0;
            state_q    <= SEED;
            mode_q     <= 2'd0;
            prbs_sel_q <= 2'd0;
            inj_q      <= 1'b0;
            pending_q  <= 1'b0;
            phase_q    <= 1'b0;
        end else begin
            dout_q     <= dout_d;
            inj_cnt_q  <= inj_cnt_d;
            state_q    <= state_d;
            mode_q     <= mode_d;
            prbs_sel_q <= prbs_sel_d;
            inj_q      <= inj_error;
            pending_q  <= pending_d;
            phase_q    <= phase_d;
        end
    end

    assign dout    = dout_q;
    assign inj_cnt = inj_cnt_q;
endmodule

// File: tb/tb_tx_pattern_engine.sv
// Directed bench for tx_pattern_engine: one straight-line sequence against two
// instances (no reorder / reorder) with a bit-serial LFSR reference model.
module tb_tx_pattern_engine;
    localparam logic [30:0] SEED = 31'h7FFFFFFF;

    logic        clk = 1'b0;
    logic        rst, cke, inj_error;
    logic [1:0]  mode, prbs_sel;
    logic [15:0] din, pat;
    logic [15:0] dout0, dout1;
    logic [7:0]  cnt0, cnt1;

    int tests = 0;
    int fails = 0;
    logic [30:0] mst;
    logic [15:0] exp_w, seen;

    always #5 clk = ~clk;

    tx_pattern_engine #(.WIDTH(16), .NLANE(4), .REORDER(1'b0), .SEED(SEED)) u0 (
        .clk(clk), .rst(rst), .cke(cke), .mode(mode), .prbs_sel(prbs_sel),
        .din(din), .pat(pat), .inj_error(inj_error), .dout(dout0), .inj_cnt(cnt0));

    tx_pattern_engine #(.WIDTH(16), .NLANE(4), .REORDER(1'b1), .SEED(SEED)) u1 (
        .clk(clk), .rst(rst), .cke(cke), .mode(mode), .prbs_sel(prbs_sel),
        .din(din), .pat(pat), .inj_error(inj_error), .dout(dout1), .inj_cnt(cnt1));

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Bit-serial reference: one LFSR step per transmitted bit, MSB first.
    function automatic logic [15:0] model_word(input int sel);
        logic [15:0] w;
        logic b;
        w = '0;
        for (int k = 0; k < 16; k++) begin
            case (sel)
                0:       b = mst[6]  ^ mst[5];
                1:       b = mst[14] ^ mst[13];
                default: b = mst[30] ^ mst[27];
            endcase
            mst = {mst[29:0], b};
            w[15-k] = b;
        end
        return w;
    endfunction

    initial begin
        int j, idx;
        rst = 1'b1; cke = 1'b1; inj_error = 1'b0; mode = 2'd0; prbs_sel = 2'd0;
        din = 16'h0; pat = 16'h0;
        tick; tick;
        chk("reset_dout", {16'h0, dout0}, 32'h0);
        chk("reset_dout_r", {16'h0, dout1}, 32'h0);
        chk("reset_cnt", {24'h0, cnt0}, 32'h0);

        rst = 1'b0; din = 16'h1234;
        tick;
        chk("pass_1234", {16'h0, dout0}, 32'h1234);

        din = 16'h8000; tick; chk("reorder_8000", {16'h0, dout1}, 32'h0001);
        din = 16'h4000; tick; chk("reorder_4000", {16'h0, dout1}, 32'h0010);
        din = 16'h0800; tick; chk("reorder_0800", {16'h0, dout1}, 32'h0004);
        din = 16'h0001; tick; chk("reorder_0001", {16'h0, dout1}, 32'h8000);
        seen = '0;
        for (int i = 0; i < 16; i++) begin
            din = 16'h1 << i;
            tick;
            j   = 15 - i;
            idx = 4 * (j % 4) + ((((j / 4) & 1) << 1) | (((j / 4) >> 1) & 1));
            chk("reorder_walk", {16'h0, dout1}, 32'h1 << idx);
            seen = seen | dout1;
        end
        chk("reorder_bijection", {16'h0, seen}, 32'hFFFF);

        mode = 2'd1; prbs_sel = 2'd0; mst = SEED;
        tick;
        chk("prbs7_first", {16'h0, dout0}, 32'h020C);
        exp_w = model_word(0);
        chk("prbs7_model0", {16'h0, dout0}, {16'h0, exp_w});
        for (int i = 1; i < 200; i++) begin
            tick;
            exp_w = model_word(0);
            chk("prbs7_seq", {16'h0, dout0}, {16'h0, exp_w});
            if (i == 127) chk("prbs7_period", {16'h0, dout0}, 32'h020C);
        end

        prbs_sel = 2'd1; mst = SEED;
        for (int i = 0; i < 10000; i++) begin
            tick;
            exp_w = model_word(1);
            chk("prbs15_seq", {16'h0, dout0}, {16'h0, exp_w});
        end
        prbs_sel = 2'd2; mst = SEED;
        for (int i = 0; i < 10000; i++) begin
            tick;
            exp_w = model_word(2);
            chk("prbs31_seq", {16'h0, dout0}, {16'h0, exp_w});
        end

        prbs_sel = 2'd0; mst = SEED;
        tick;
        chk("reseed_sel", {16'h0, dout0}, 32'h020C);
        exp_w = model_word(0);
        for (int i = 0; i < 4; i++) begin
            tick;
            exp_w = model_word(0);
            chk("prbs7_pre_hold", {16'h0, dout0}, {16'h0, exp_w});
        end
        cke = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick;
            chk("cke_hold", {16'h0, dout0}, {16'h0, exp_w});
        end
        cke = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick;
            exp_w = model_word(0);
            chk("cke_resume", {16'h0, dout0}, {16'h0, exp_w});
        end

        inj_error = 1'b1;
        tick;
        exp_w = model_word(0);
        chk("inj_flip", {16'h0, dout0}, {16'h0, exp_w ^ 16'h8000});
        for (int i = 0; i < 2; i++) begin
            tick;
            exp_w = model_word(0);
            chk("inj_absorb", {16'h0, dout0}, {16'h0, exp_w});
        end
        inj_error = 1'b0;
        chk("inj_cnt_1", {24'h0, cnt0}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            tick;
            exp_w = model_word(0);
            chk("inj_after", {16'h0, dout0}, {16'h0, exp_w});
        end

        mode = 2'd2; pat = 16'h0000;
        tick;
        chk("static_zero", {16'h0, dout0}, 32'h0);
        cke = 1'b0; inj_error = 1'b1;
        tick;
        inj_error = 1'b0;
        tick;
        chk("inj_cke0_hold", {16'h0, dout0}, 32'h0);
        chk("inj_cke0_cnt", {24'h0, cnt0}, 32'd1);
        cke = 1'b1;
        tick;
        chk("inj_cke0_flip", {16'h0, dout0}, 32'h8000);
        chk("inj_cnt_2", {24'h0, cnt0}, 32'd2);

        for (int i = 3; i <= 302; i++) begin
            inj_error = 1'b1;
            tick;
            chk("pulse_flip", {16'h0, dout0}, 32'h8000);
            inj_error = 1'b0;
            tick;
            chk("pulse_clean", {16'h0, dout0}, 32'h0);
            if (i == 254) chk("inj_cnt_254", {24'h0, cnt0}, 32'd254);
            if (i == 255) chk("inj_cnt_255", {24'h0, cnt0}, 32'd255);
        end
        chk("inj_cnt_sat", {24'h0, cnt0}, 32'd255);

        mode = 2'd3; pat = 16'hA5F0;
        tick; chk("toggle_0", {16'h0, dout0}, 32'hA5F0);
        tick; chk("toggle_1", {16'h0, dout0}, 32'h5A0F);
        tick; chk("toggle_2", {16'h0, dout0}, 32'hA5F0);
        tick; chk("toggle_3", {16'h0, dout0}, 32'h5A0F);
        mode = 2'd0; din = 16'h0000;
        tick; chk("toggle_leave", {16'h0, dout0}, 32'h0);
        mode = 2'd3;
        tick; chk("toggle_reenter", {16'h0, dout0}, 32'hA5F0);
        tick; chk("toggle_reenter1", {16'h0, dout0}, 32'h5A0F);

        mode = 2'd1; prbs_sel = 2'd0;
        tick; tick;
        rst = 1'b1;
        tick;
        chk("rst_mid_dout", {16'h0, dout0}, 32'h0);
        chk("rst_mid_cnt", {24'h0, cnt0}, 32'h0);
        rst = 1'b0;
        tick;
        chk("rst_prbs_first", {16'h0, dout0}, 32'h020C);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/tx_pattern_engine.md
Name: tx_pattern_engine

Overview:
- Parametrised parallel data source for the TX serializer path, clocked by the PRBS-rate divided clock.
- Drives the WIDTH-bit input of the half-rate mux tree.
- Modes: registered pass-through of external data, multi-polynomial parallel PRBS, static pattern, and toggle pattern.
- Adds one-shot error injection with a saturating injection counter, and an optional interleave reorder for an NLANE-way quarter-rate mux.

Parameters:
- WIDTH, 16: parallel word width. Must equal NLANE*M, where M is a power of two.
- NLANE, 4: quarter-rate interleave factor of the downstream mux.
- REORDER, 1: 1 applies the interleave bit map to dout; 0 passes bits straight through.
- SEED, 31'h7FFFFFFF: LFSR reload value; low bits are used for shorter polynomials.

Ports:
- clk  in  1  word clock; all logic is on its rising edge.
- rst  in  1  synchronous, active-high reset.
- cke  in  1  word enable; when 0, dout and all sequence state hold.
- mode  in  2  0 = pass din, 1 = PRBS, 2 = static pat, 3 = toggle pat/~pat.
- prbs_sel  in  2  0 = PRBS7 (x^7+x^6+1), 1 = PRBS15 (x^15+x^14+1), 2 and 3 = PRBS31 (x^31+x^28+1).
- din  in  WIDTH  external parallel data; bit WIDTH-1 is transmitted first.
- pat  in  WIDTH  pattern word for modes 2 and 3.
- inj_error  in  1  error injection request; acts on its rising edge.
- dout  out  WIDTH  word to the mux tree, registered.
- inj_cnt  out  8  number of injected errors, saturating at 255.

Behaviour:
- Reset, taking priority over everything including cke:
  - dout = 0, inj_cnt = 0.
  - LFSR state = SEED, mode_q = 0, prbs_sel_q = 0.
  - inj_q = 0, pending = 0, phase = 0.
- Latency: exactly one clk from sampled inputs to dout in every mode. inj_q updates every cycle.
- mode_q and prbs_sel_q update only on cke = 1 cycles, so a config change made during cke = 0 is detected at the next cke = 1 cycle.
- Raw word formation, computed only when cke = 1:
  - Mode 0: raw = din.
  - Mode 2: raw = pat.
  - Mode 3: raw = phase ? ~pat : pat; phase toggles. If mode_q != 3, phase is treated as 0, so the first word after entry is pat.
  - Mode 1, generation:
    - base = reseed ? SEED : state.
    - reseed is true if mode_q != 1, or prbs_sel != prbs_sel_q, or the selected-length slice of base is all zero.
    - Fibonacci LFSR, N = 7/15/31 using low N bits: new = s[N-1]^s[t-1] (t = 6/14/28); s = {s[N-2:0], new}.
    - Step WIDTH times in one cycle; the k-th new bit (k = 0 first) goes to raw[WIDTH-1-k].
    - State after WIDTH steps is stored. State bits above N-1 are don't-care and are stored as 0.
  - In modes other than 1, LFSR state holds.
- Error injection:
  - A rising edge (inj_error & ~inj_q) sets pending.
  - The next cke = 1 word, including one in the same cycle as the edge, is emitted with raw[WIDTH-1] inverted.
  - On that word, pending clears and inj_cnt increments unless it is 255.
  - Further edges while pending is set are absorbed: one flip, one count.
  - Injection never alters LFSR state. It applies in all modes.
- Reorder, applied after injection, with M = WIDTH/NLANE:
  - For a in 0..M-1 and b in 0..NLANE-1: out[M*b + rev(a)] = raw[WIDTH-1-(NLANE*a+b)].
  - rev is the log2(M)-bit bit reversal.
  - REORDER = 0 gives out = raw.
- cke = 0: dout, state, phase, pending and inj_cnt hold. An inj_error edge during cke = 0 still sets pending.
- rst asserted mid-stream: next dout = 0. The first PRBS word after release, with mode = 1, starts from SEED, because mode_q = 0 forces a reseed.
- Illegal all-zero LFSR state, reachable only through a bad SEED: auto reseed; no lock-up.

Test Plan:
- Reset and passthrough, REORDER = 0: rst high for 2 cycles → dout = 0x0000, inj_cnt = 0. Then mode = 0, din = 0x1234 → dout = 0x1234 one cycle later.
- Reorder map, REORDER = 1, mode = 0:
  - din = 0x8000 → 0x0001.
  - din = 0x4000 → 0x0010.
  - din = 0x0800 → 0x0004.
  - din = 0x0001 → 0x8000.
  - Walk all 16 one-hot inputs and confirm a bijection.
- PRBS7 sequence, REORDER = 0, default SEED:
  - Enter mode = 1 with prbs_sel = 0 → first word 0x020C.
  - Each following word matches a bit-serial x^7+x^6+1 model.
  - Period is 127 bits. Repeat for PRBS15 and PRBS31 against the model over 10^4 words.
- Reseed and cke:
  - Change prbs_sel mid-stream → the next word restarts from SEED.
  - Hold cke = 0 for 5 cycles → dout is frozen, and the sequence resumes with no skipped bits.
- Error injection:
  - Pulse inj_error for 3 cycles in PRBS7 → exactly one word differs from the model, only in bit 15, and inj_cnt = 1.
  - The following words match the model.
  - 300 separate pulses → inj_cnt saturates at 255.
- Toggle mode: mode = 3, pat = 0xA5F0 → 0xA5F0, 0x5A0F, 0xA5F0, … Leave and re-enter mode 3 → the first word is 0xA5F0 again.
